// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: a small valid/ready FIFO holding ALU results and
// memory/writeback control. Taken branches become a one-cycle registered PC
// redirect, and the beat that follows them down the wrong path is squashed.
// The head entry doubles as a forwarding source for the EX operand bypass.
module ex_mem_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic            in_bit_branch,
   input  logic            in_is_branch,
   input  logic [XLEN-1:0] in_br_target,
   input  logic [XLEN-1:0] in_store_data,
   input  logic [4:0]      in_rd,
   input  logic            in_regwrite,
   input  logic            in_memread,
   input  logic            in_memwrite,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_alu_result,
   output logic [XLEN-1:0] out_store_data,
   output logic [4:0]      out_rd,
   output logic            out_regwrite,
   output logic            out_memread,
   output logic            out_memwrite,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            fwd_valid,
   output logic [4:0]      fwd_rd,
   output logic [XLEN-1:0] fwd_data,
   output logic [31:0]     stall_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] store_data;
      logic [4:0]      rd;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic [31:0]     stall_cnt_q, stall_cnt_d;

   logic   accept, push, pop, take_branch;
   entry_t in_entry, head;

   // Handshake decode; in_ready depends on registered state only.
   always_comb begin
      in_ready    = (count_q < FULL_CNT) | redirect_valid_q;
      out_valid   = (count_q != '0);
      accept      = in_valid & in_ready & ~flush & ~redirect_valid_q;
      push        = accept & ~in_is_branch;
      take_branch = accept & in_is_branch & in_bit_branch;
      pop         = out_valid & out_ready;
   end

   // Pack the incoming beat; branch fields are consumed here, never stored.
   always_comb begin
      in_entry            = '0;
      in_entry.alu_result = in_alu_result;
      in_entry.store_data = in_store_data;
      in_entry.rd         = in_rd;
      in_entry.regwrite   = in_regwrite;
      in_entry.memread    = in_memread;
      in_entry.memwrite   = in_memwrite;
   end

   // Head entry, forced to zero while empty so unwritten storage never leaks out.
   always_comb begin
      head           = out_valid ? mem_q[rd_ptr_q] : '0;
      out_alu_result = head.alu_result;
      out_store_data = head.store_data;
      out_rd         = head.rd;
      out_regwrite   = head.regwrite;
      out_memread    = head.memread;
      out_memwrite   = head.memwrite;
      fwd_valid      = out_valid & head.regwrite & ~head.memread & (head.rd != 5'd0);
      fwd_rd         = head.rd;
      fwd_data       = head.alu_result;
      redirect_valid = redirect_valid_q;
      redirect_pc    = redirect_pc_q;
      stall_cnt      = stall_cnt_q;
   end

   // Next-state: FIFO pointers/occupancy, redirect pulse and stall counter.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_entry;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // A flush discards everything; a pop in the same cycle has still reached MEM.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
      redirect_valid_d = take_branch;
      redirect_pc_d    = take_branch ? in_br_target : redirect_pc_q;
      stall_cnt_d      = stall_cnt_q + 32'(out_valid & ~out_ready);
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         stall_cnt_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         stall_cnt_q      <= stall_cnt_d;
      end
   end

   // Entry storage.
   // NOTE: storage is not reset; it is only read when count_q says it was written,
   // and the head mux zeroes the outputs otherwise.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed beats; expected MEM-side beats go into a
// scoreboard queue, and a monitor pops and compares on every out handshake.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_alu_result;
   logic        in_bit_branch;
   logic        in_is_branch;
   logic [31:0] in_br_target;
   logic [31:0] in_store_data;
   logic [4:0]  in_rd;
   logic        in_regwrite;
   logic        in_memread;
   logic        in_memwrite;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_alu_result;
   logic [31:0] out_store_data;
   logic [4:0]  out_rd;
   logic        out_regwrite;
   logic        out_memread;
   logic        out_memwrite;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic [31:0] stall_cnt;

   typedef struct {
      logic [31:0] res;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
   } exp_t;

   exp_t sb_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   ex_mem_stage #(.XLEN(32), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_result(in_alu_result), .in_bit_branch(in_bit_branch),
      .in_is_branch(in_is_branch), .in_br_target(in_br_target),
      .in_store_data(in_store_data), .in_rd(in_rd),
      .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu_result(out_alu_result), .out_store_data(out_store_data),
      .out_rd(out_rd), .out_regwrite(out_regwrite),
      .out_memread(out_memread), .out_memwrite(out_memwrite),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Present one beat and hold it until accepted (bounded); returns 1 time unit after the accepting edge.
   task automatic drive_beat(input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd,
                             input logic rw, input logic mr, input logic mw,
                             input logic is_br, input logic bb, input logic [31:0] tgt,
                             input bit expect_out);
      int n;
      in_valid      = 1'b1;
      in_alu_result = res;
      in_store_data = sd;
      in_rd         = rd;
      in_regwrite   = rw;
      in_memread    = mr;
      in_memwrite   = mw;
      in_is_branch  = is_br;
      in_bit_branch = bb;
      in_br_target  = tgt;
      if (expect_out) sb_q.push_back('{res, sd, rd, rw, mr, mw});
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         total_cnt++;
         $display("FAIL accept_timeout: beat 0x%08h not accepted within 20 cycles", res);
      end
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      in_is_branch = 1'b0;
      in_bit_branch = 1'b0;
   endtask

   // Monitor: every out handshake must match the oldest expected beat.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_pop: got result 0x%08h, expected no beat", out_alu_result);
            end else begin
               e = sb_q.pop_front();
               check("pop_result", out_alu_result, e.res);
               check("pop_store_data", out_store_data, e.sd);
               check("pop_ctrl", {24'd0, out_rd, out_regwrite, out_memread, out_memwrite},
                     {24'd0, e.rd, e.rw, e.mr, e.mw});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_alu_result = '0; in_bit_branch = 1'b0; in_is_branch = 1'b0; in_br_target = '0;
      in_store_data = '0; in_rd = '0; in_regwrite = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0;

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_redirect_valid", redirect_valid, 0);
      check("rst_redirect_pc", redirect_pc, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_fwd_valid", fwd_valid, 0);
      check("rst_out_result", out_alu_result, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: stream of 4 ADD beats, MEM always ready
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_beat(32'h100 + 32'(i), 32'h0, 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         check("s1_out_valid_latency", out_valid, 1);
         check("s1_in_ready", in_ready, 1);
      end
      @(posedge clk); #1;
      check("s1_drained", out_valid, 0);

      // 2: backpressure; A, B stored, C held while full
      out_ready = 1'b0;
      drive_beat(32'hA, 32'hA0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      drive_beat(32'hB, 32'hB0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      in_valid = 1'b1; in_alu_result = 32'hC; in_store_data = 32'hC0; in_rd = 5'd12;
      in_regwrite = 1'b0; in_memread = 1'b1; in_memwrite = 1'b0;
      sb_q.push_back('{32'hC, 32'hC0, 5'd12, 1'b0, 1'b1, 1'b0});
      repeat (3) @(posedge clk);
      #1;
      check("s2_in_ready_full", in_ready, 0);
      check("s2_stall_cnt", stall_cnt, 4);
      check("s2_head_is_A", out_alu_result, 32'hA);
      out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("s2_c_accept_in_time", 32'(n < 10), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("s2_drained", out_valid, 0);
      check("s2_stall_hold", stall_cnt, 4);

      // 3: taken branch -> redirect pulse and squash; not-taken -> nothing
      drive_beat(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 1'b0);
      check("s3_redirect_valid", redirect_valid, 1);
      check("s3_redirect_pc", redirect_pc, 32'h80);
      check("s3_in_ready_squash", in_ready, 1);
      drive_beat(32'h1234, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("s3_redirect_one_cycle", redirect_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      check("s3_squashed_absent", out_valid, 0);
      drive_beat(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b0);
      check("s3_not_taken_no_pulse", redirect_valid, 0);
      check("s3_not_taken_not_stored", out_valid, 0);

      // 4: full FIFO flushed while another beat is presented
      out_ready = 1'b0;
      drive_beat(32'hD, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      drive_beat(32'hE, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      in_valid = 1'b1; in_alu_result = 32'hF; in_rd = 5'd6;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      sb_q.delete();
      check("s4_out_valid_cleared", out_valid, 0);
      check("s4_in_ready", in_ready, 1);
      check("s4_stall_incl_flush", stall_cnt, 6);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("s4_beat_dropped", out_valid, 0);

      // 5: forwarding qualifiers on the head entry
      out_ready = 1'b0;
      drive_beat(32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("s5_fwd_valid", fwd_valid, 1);
      check("s5_fwd_data", fwd_data, 32'hDEAD_BEEF);
      check("s5_fwd_rd", fwd_rd, 5);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive_beat(32'h5555_0000, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("s5_fwd_rd0", fwd_valid, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive_beat(32'h0000_2000, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("s5_fwd_load", fwd_valid, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("s5_stall_unchanged", stall_cnt, 6);

      // 6: async reset with an entry and a redirect pending
      out_ready = 1'b0;
      drive_beat(32'h0000_0AAA, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      drive_beat(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b0);
      check("s6_pre_redirect", redirect_valid, 1);
      check("s6_pre_out_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      sb_q.delete();
      check("s6_out_valid", out_valid, 0);
      check("s6_redirect_valid", redirect_valid, 0);
      check("s6_redirect_pc", redirect_pc, 0);
      check("s6_in_ready", in_ready, 1);
      check("s6_stall_cnt", stall_cnt, 0);
      check("s6_out_result", out_alu_result, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive_beat(32'h0000_0BBB, 32'h0000_0CCC, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("s6_post_reset_drained", out_valid, 0);

      check("sb_drained", 32'(sb_q.size()), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
